// File: rtl/arm_run_controller_if.sv
// Board-side bundle for the run/halt sequencer: debounced keys and breakpoint inputs in,
// core control and debug status out.
interface arm_run_controller_if #(
   parameter int unsigned PC_W = 32
);
   logic            key_run;
   logic            key_step;
   logic            break_en;
   logic [PC_W-1:0] break_pc;
   logic [PC_W-1:0] if_pc;
   logic            core_rst;
   logic            core_freeze;
   logic            ila_trig;
   logic [1:0]      state;
   logic [31:0]     cycle_count;

   modport master (
      output key_run, key_step, break_en, break_pc, if_pc,
      input  core_rst, core_freeze, ila_trig, state, cycle_count
   );

   modport slave (
      input  key_run, key_step, break_en, break_pc, if_pc,
      output core_rst, core_freeze, ila_trig, state, cycle_count
   );
endinterface

// File: rtl/arm_run_controller.sv
// Run/halt/single-step sequencer for the pipeline core: stretched core reset, pipeline
// freeze, PC breakpoint with ILA trigger and an unfrozen-cycle counter.
module arm_run_controller #(
   parameter int unsigned RST_CYCLES = 16,
   parameter int unsigned PC_W       = 32
) (
   input logic                 clk,
   input logic                 rst,
   arm_run_controller_if.slave bus
);

   localparam int unsigned CntW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [CntW-1:0] RstLoad = CntW'(RST_CYCLES - 1);

   typedef enum logic [1:0] {
      StReset = 2'b00,
      StHalt  = 2'b01,
      StRun   = 2'b10,
      StStep  = 2'b11
   } state_e;

   state_e          state_q;
   logic [CntW-1:0] rst_cnt_q;
   logic            rst_hold_q;
   logic            run_key_q, run_prev_q;
   logic            step_key_q, step_prev_q;
   logic            core_rst_q;
   logic            freeze_q;
   logic            trig_q;
   logic [31:0]     cycle_q;

   logic [PC_W-1:0] fetch_pc;
   logic [PC_W-1:0] brk_pc;
   logic            run_edge;
   logic            step_edge;
   logic            bp_hit;

   assign fetch_pc  = bus.if_pc;
   assign brk_pc    = bus.break_pc;
   assign run_edge  = run_key_q & ~run_prev_q;
   assign step_edge = step_key_q & ~step_prev_q;
   assign bp_hit    = bus.break_en & (fetch_pc == brk_pc);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StReset;
         rst_cnt_q   <= RstLoad;
         rst_hold_q  <= 1'b1;
         // Key flops preset high so a key held through reset never looks like a press.
         run_key_q   <= 1'b1;
         run_prev_q  <= 1'b1;
         step_key_q  <= 1'b1;
         step_prev_q <= 1'b1;
         core_rst_q  <= 1'b1;
         freeze_q    <= 1'b1;
         trig_q      <= 1'b0;
         cycle_q     <= 32'd0;
      end else begin
         rst_hold_q  <= 1'b0;
         run_key_q   <= bus.key_run;
         run_prev_q  <= run_key_q;
         step_key_q  <= bus.key_step;
         step_prev_q <= step_key_q;
         trig_q      <= 1'b0;

         if (!freeze_q) begin
            cycle_q <= cycle_q + 32'd1;
         end

         unique case (state_q)
            StReset: begin
               // The first edge after release only drops rst_hold_q, stretching by one cycle.
               if (!rst_hold_q) begin
                  if (rst_cnt_q == '0) begin
                     state_q    <= StHalt;
                     core_rst_q <= 1'b0;
                  end else begin
                     rst_cnt_q <= rst_cnt_q - CntW'(1);
                  end
               end
            end
            StHalt: begin
               if (run_edge) begin
                  state_q  <= StRun;
                  freeze_q <= 1'b0;
               end else if (step_edge) begin
                  state_q  <= StStep;
                  freeze_q <= 1'b0;
               end
            end
            StStep: begin
               state_q  <= StHalt;
               freeze_q <= 1'b1;
            end
            StRun: begin
               if (bp_hit) begin
                  state_q  <= StHalt;
                  freeze_q <= 1'b1;
                  trig_q   <= 1'b1;
               end else if (run_edge) begin
                  state_q  <= StHalt;
                  freeze_q <= 1'b1;
               end
            end
            default: begin
               state_q <= StReset;
            end
         endcase
      end
   end

   assign bus.state       = state_q;
   assign bus.core_rst    = core_rst_q;
   assign bus.core_freeze = freeze_q;
   assign bus.ila_trig    = trig_q;
   assign bus.cycle_count = cycle_q;

endmodule

// File: tb/tb_arm_run_controller.sv
// Scoreboarded bench for arm_run_controller: a time-based reference model queues the expected
// outputs per cycle, a monitor compares them; directed checks cover the key scenarios.
module tb_arm_run_controller;

   localparam int RST_CYCLES = 16;
   localparam int M_RESET = 0;
   localparam int M_HALT  = 1;
   localparam int M_RUN   = 2;
   localparam int M_STEP  = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   arm_run_controller_if #(.PC_W(32)) bus ();

   arm_run_controller #(
      .RST_CYCLES(RST_CYCLES),
      .PC_W      (32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   typedef struct packed {
      logic [1:0]  st;
      logic        crst;
      logic        frz;
      logic        trig;
      logic [31:0] cnt;
   } obs_t;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state: mode, time of last reset, last two sampled key levels.
   int          m_mode = M_RESET;
   int          m_t = 0;
   int          m_last_rst = 0;
   logic [31:0] m_cnt = 0;
   bit          m_trig = 0;
   bit          kr1 = 1, kr2 = 1, ks1 = 1, ks2 = 1;
   logic [31:0] pc = 0;
   bit          tb_ben = 0;
   logic [31:0] tb_bpc = 0;

   function automatic obs_t model_obs();
      obs_t o;
      o.st   = 2'(m_mode);
      o.crst = (m_mode == M_RESET);
      o.frz  = !(m_mode == M_RUN || m_mode == M_STEP);
      o.trig = m_trig;
      o.cnt  = m_cnt;
      return o;
   endfunction

   task automatic model_step(bit r, bit kr, bit ks);
      bit unfrozen = (m_mode == M_RUN) || (m_mode == M_STEP);
      bit re       = kr1 & ~kr2;
      bit se       = ks1 & ~ks2;
      bit hit      = tb_ben && (pc == tb_bpc);
      m_t++;
      m_trig = 0;
      if (r) begin
         m_mode     = M_RESET;
         m_last_rst = m_t;
         m_cnt      = 0;
         kr1 = 1; kr2 = 1; ks1 = 1; ks2 = 1;
         pc = 0;
         return;
      end
      if (unfrozen) m_cnt = m_cnt + 1;
      case (m_mode)
         M_RESET: if (m_t - m_last_rst == RST_CYCLES + 1) m_mode = M_HALT;
         M_HALT:  if (re) m_mode = M_RUN; else if (se) m_mode = M_STEP;
         M_STEP:  m_mode = M_HALT;
         default: begin
            if (hit) begin
               m_mode = M_HALT;
               m_trig = 1;
            end else if (re) begin
               m_mode = M_HALT;
            end
         end
      endcase
      kr2 = kr1; kr1 = kr;
      ks2 = ks1; ks1 = ks;
      // The emulated core fetches pc this cycle and advances only when unfrozen.
      if (unfrozen) pc = pc + 4;
   endtask

   // One clock of stimulus: drive at the falling edge, queue the expected post-edge outputs.
   task automatic cyc(bit r, bit kr, bit ks);
      @(negedge clk);
      rst          = r;
      bus.key_run  = kr;
      bus.key_step = ks;
      bus.break_en = tb_ben;
      bus.break_pc = tb_bpc;
      bus.if_pc    = pc;
      model_step(r, kr, ks);
      exp_q.push_back(model_obs());
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   initial begin
      forever begin
         obs_t e;
         obs_t a;
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.state, bus.core_rst, bus.core_freeze, bus.ila_trig, bus.cycle_count};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL cycle_obs t=%0t got st=%0d rst=%0b frz=%0b trig=%0b cnt=0x%0h expected st=%0d rst=%0b frz=%0b trig=%0b cnt=0x%0h",
                          $time, a.st, a.crst, a.frz, a.trig, a.cnt, e.st, e.crst, e.frz, e.trig, e.cnt);
         end
      end
   end

   initial begin
      int n;
      int budget;
      bit klr, kls;
      rst = 1'b1;
      bus.key_run = 1'b0; bus.key_step = 1'b0; bus.break_en = 1'b0;
      bus.break_pc = '0;  bus.if_pc = '0;

      // Reset values and stretch length
      repeat (3) cyc(1, 0, 0);
      settle();
      chk("reset_state", bus.state, 0);
      chk("reset_core_rst", bus.core_rst, 1);
      chk("reset_freeze", bus.core_freeze, 1);
      chk("reset_trig", bus.ila_trig, 0);
      chk("reset_count", bus.cycle_count, 0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(0, 0, 0); settle();
         if (bus.core_rst) n++;
      end
      chk("reset_stretch_len", n, 16);
      chk("halt_after_reset", bus.state, 1);
      chk("halt_freeze", bus.core_freeze, 1);
      chk("halt_count", bus.cycle_count, 0);

      // Three single steps
      n = 0;
      for (int p = 0; p < 3; p++) begin
         cyc(0, 0, 1); settle(); if (!bus.core_freeze) n++;
         cyc(0, 0, 1); settle(); if (!bus.core_freeze) n++;
         for (int j = 0; j < 3; j++) begin
            cyc(0, 0, 0); settle(); if (!bus.core_freeze) n++;
         end
      end
      chk("step_unfrozen_cycles", n, 3);
      chk("step_count", bus.cycle_count, 3);
      chk("step_state", bus.state, 1);

      // Run for 100 cycles, step key pressed during RUN
      cyc(0, 1, 0);
      for (int i = 1; i < 100; i++) begin
         cyc(0, 0, (i >= 10 && i < 50));
         if (i == 60) begin
            settle();
            chk("run_ignores_step", bus.state, 2);
         end
      end
      cyc(0, 1, 0);
      repeat (3) cyc(0, 0, 0);
      settle();
      chk("run_toggle_count", bus.cycle_count, 103);
      chk("run_toggle_state", bus.state, 1);

      // Breakpoint at 0x20
      repeat (2) cyc(1, 0, 0);
      repeat (18) cyc(0, 0, 0);
      settle();
      chk("bp_pre_state", bus.state, 1);
      tb_ben = 1; tb_bpc = 32'h20;
      cyc(0, 1, 0);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(0, 0, 0); settle();
         if (bus.ila_trig) n++;
      end
      chk("bp_trig_pulses", n, 1);
      chk("bp_count", bus.cycle_count, 9);
      chk("bp_state", bus.state, 1);
      // Step over a matching PC: matches outside RUN never trigger
      tb_bpc = 32'h24;
      cyc(0, 0, 1); cyc(0, 0, 1);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0); settle();
         if (bus.ila_trig) n++;
      end
      chk("step_over_no_trig", n, 0);
      chk("step_over_count", bus.cycle_count, 10);
      chk("step_over_state", bus.state, 1);

      // Run and step edges together in HALT
      tb_ben = 0;
      cyc(0, 1, 1); cyc(0, 0, 0); settle();
      chk("run_step_same_cycle", bus.state, 2);

      // Run edge and breakpoint hit on the same edge
      tb_ben = 1; tb_bpc = 32'hFFFF_FFF0;
      repeat (5) cyc(0, 0, 0);
      cyc(0, 1, 0);
      tb_bpc = pc;
      cyc(0, 0, 0); settle();
      chk("run_and_hit_trig", bus.ila_trig, 1);
      chk("run_and_hit_state", bus.state, 1);
      chk("run_and_hit_freeze", bus.core_freeze, 1);
      cyc(0, 0, 0); settle();
      chk("trig_one_cycle", bus.ila_trig, 0);

      // Keys held through reset
      tb_ben = 0;
      repeat (3) cyc(1, 1, 1);
      repeat (25) cyc(0, 1, 1);
      settle();
      chk("held_keys_state", bus.state, 1);
      repeat (3) cyc(0, 0, 0);
      settle();
      chk("held_keys_release_state", bus.state, 1);
      chk("held_keys_count", bus.cycle_count, 0);

      // Reset mid-run at cycle_count 0x1234
      cyc(0, 1, 0);
      budget = 6000;
      while (m_cnt != 32'h1234 && budget > 0) begin
         cyc(0, 0, 0);
         budget--;
      end
      settle();
      chk("mid_run_count", bus.cycle_count, 32'h1234);
      chk("mid_run_state", bus.state, 2);
      cyc(1, 0, 0); settle();
      chk("mid_rst_state", bus.state, 0);
      chk("mid_rst_core_rst", bus.core_rst, 1);
      chk("mid_rst_freeze", bus.core_freeze, 1);
      chk("mid_rst_count", bus.cycle_count, 0);
      chk("mid_rst_trig", bus.ila_trig, 0);

      // Randomized traffic, checked cycle by cycle against the model
      repeat (20) cyc(0, 0, 0);
      klr = 0; kls = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) klr = ~klr;
         if ($urandom_range(0, 7) == 0) kls = ~kls;
         if ($urandom_range(0, 49) == 0) tb_ben = ~tb_ben;
         tb_bpc = ($urandom_range(0, 5) == 0) ? pc : 32'h100;
         cyc(($urandom_range(0, 399) == 0), klr, kls);
      end

      repeat (2) @(posedge clk);
      #3;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/arm_run_controller.md
# arm_run_controller

Board-level run/halt sequencer for the ARM pipeline core. It sits between the debounced board keys and the core. It generates a stretched core reset and a pipeline freeze. It provides run, halt and single-step control, plus a PC breakpoint that halts the core and pulses an ILA trigger. It also keeps an active-cycle counter for on-chip debug probing.

## Interface
Parameters:
- RST_CYCLES, 16: cycles `core_rst` stays high after `rst` deasserts (≥1)
- PC_W, 32: width of PC compare

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- key_run  in  1  debounced run/halt toggle key (level)
- key_step  in  1  debounced single-step key (level)
- break_en  in  1  breakpoint enable
- break_pc  in  PC_W  breakpoint address
- if_pc  in  PC_W  current fetch PC from core IF stage
- core_rst  out  1  reset to core, registered
- core_freeze  out  1  freeze to all core pipeline registers and PC, registered
- ila_trig  out  1  one-cycle pulse on breakpoint hit
- state  out  2  RESET=00, HALT=01, RUN=10, STEP=11
- cycle_count  out  32  count of unfrozen core cycles

## Operation
- **Key edges.** Each key has a registered previous-value flop. A rising edge is `key & ~prev`. `rst` sets both prev flops to 1, so a key held through reset gives no edge.
- **RESET.** `core_rst=1`, `core_freeze=1`. A down-counter is loaded with RST_CYCLES-1 while `rst` is high. It decrements each cycle once `rst` is low. At 0 the next state is HALT. Key edges are ignored in RESET.
- **HALT.** `core_rst=0`, `core_freeze=1`.
  - run edge → RUN.
  - step edge (without a run edge) → STEP.
  - Run and step edges in the same cycle → RUN; the step is dropped.
- **STEP.** `core_freeze=0` for exactly one cycle, then → HALT unconditionally. Key edges in STEP are ignored.
- **RUN.** `core_freeze=0`.
  - run edge → HALT.
  - Breakpoint hit (`break_en` and `if_pc==break_pc`) → HALT, with `ila_trig` pulsed.
  - Run edge and hit in the same cycle → HALT, `ila_trig` still pulses.
  - step edge is ignored.
- **Breakpoint scope.** A hit is evaluated only in RUN. Matches in STEP or HALT never trigger, so stepping over the breakpoint PC is allowed.
- **cycle_count.**
  - Increments by 1 in every cycle where `core_freeze==0`.
  - Wraps 0xFFFFFFFF→0.
  - Holds otherwise.
  - Cleared only by `rst`.
- **Reset mid-operation.** `rst` in any state goes to RESET on the next edge. The counter reloads, and `cycle_count` and `ila_trig` clear.

## Timing
- **Reset values:** `state=00`, `core_rst=1`, `core_freeze=1`, `ila_trig=0`, `cycle_count=0`.
- All outputs come from flops. No combinational path from inputs to outputs.
- **Reset release.** Let `rst` be sampled high at edge N and low from edge N+1. Then `core_rst` stays 1 through edge N+RST_CYCLES. `state=HALT` and `core_rst=0` are visible after edge N+RST_CYCLES+1.
- **Key latency.** A key rising edge sampled at edge K changes `state` and `core_freeze` after edge K+1. This is one flop stage for edge detection plus the state register.
- **STEP.** Exactly one cycle with `core_freeze=0` per accepted step edge, which is one PC advance.
- **Breakpoint.** A match sampled at edge K in RUN gives `state=HALT`, `core_freeze=1` and `ila_trig=1` after edge K. The fetch of the matching PC therefore completes during cycle K. `ila_trig` returns to 0 after edge K+1.
- **Freeze semantics.** With `core_freeze` high the core holds all pipeline registers and the PC. The controller relies on this.

## Test plan
- **Reset stretch.** With RST_CYCLES=16, assert `rst` for 3 cycles then release → `core_rst` stays 1 for exactly 16 cycles after release. Then `state=01`, `core_freeze=1`, `cycle_count=0`.
- **Single step.** In HALT, give 3 separate `key_step` pulses → `core_freeze` low for exactly 3 single cycles, `cycle_count=3`, `state` returns to 01 each time.
- **Run/halt toggle.** In HALT, press run, wait 100 cycles, press run → `cycle_count` = 100 ± 0 counted from the first unfrozen cycle, and `state=01` after the second press. A step key held during RUN has no effect.
- **Breakpoint.** `break_en=1`, `break_pc=0x20`, and `if_pc` increments by 4 per unfrozen cycle from 0 in RUN. Required response:
  - When `if_pc==0x20`, `ila_trig` pulses once and `state=01`.
  - `cycle_count=9`.
  - A subsequent step advances past 0x20 without retrigger.
- **Simultaneous events.**
  - Run and step edges in the same HALT cycle → RUN.
  - Run edge and breakpoint hit in the same RUN cycle → HALT with `ila_trig=1`.
  - A key held high through `rst` → no transition after reset release.
- **Reset mid-run.** Assert `rst` in RUN with `cycle_count=0x1234` → next cycle `state=00`, `core_rst=1`, `core_freeze=1`, `cycle_count=0`, `ila_trig=0`.
